fetch_queue: RTL and testbench

Instruction buffer between the fetch stage and the decoder. Holds up to DEPTH fetched instruction words with their PCs in a circular FIFO. Uses valid/ready handshakes on both sides so fetch and decode can stall independently. Supports a single-cycle flush for branch redirects. The decoder consumes `out_instr` and `out_pc`, and its output is captured by `decode_register`.

---
 rtl/fetch_queue.sv | 96 +++++++++
 tb/tb_fetch_queue.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch and decode.
// Define FETCH_QUEUE_BYPASS_EN to forward fetch straight to decode when empty.
module fetch_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]      mem_instr [DEPTH];
  logic [31:0]      mem_pc    [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             live;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             store;
  logic             deq;

  assign empty    = (count == '0);
  assign full     = (count == FULL);

  // live holds off acceptance until the first edge that sees rst_n high
  assign in_ready = rst_n & live & ~full & ~flush;
  assign push     = in_valid & in_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass   = empty & push;
`else
  assign bypass   = 1'b0;
`endif

  assign out_valid = rst_n & ~flush & (~empty | bypass);
  assign pop       = out_valid & out_ready;

  // a forwarded entry taken by decode never touches storage
  assign store     = push & ~(bypass & out_ready);
  assign deq       = pop & ~bypass;

  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    unique case (1'b1)
      bypass: begin
        out_instr = in_instr;
        out_pc    = in_pc;
      end
      out_valid & ~empty: begin
        out_instr = mem_instr[rd_ptr];
        out_pc    = mem_pc[rd_ptr];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    live <= rst_n;
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (deq)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({store, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue
// against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  logic [63:0] q[$];
  bit          rdy_m = 1'b0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .count(count)
  );

  function automatic bit e_ready();
    return rst_n && rdy_m && q.size() < DEPTH && !flush;
  endfunction

  function automatic bit e_byp();
    return BYP && q.size() == 0 && in_valid && e_ready();
  endfunction

  function automatic bit e_valid();
    return rst_n && !flush && (q.size() != 0 || e_byp());
  endfunction

  function automatic logic [63:0] e_data();
    if (!e_valid()) return '0;
    if (q.size() == 0) return {in_instr, in_pc};
    return q[0];
  endfunction

  task automatic drive(input bit r, input bit f, input bit v,
                       input bit rd, input logic [31:0] pc);
    @(negedge clk);
    rst_n     = r;
    flush     = f;
    in_valid  = v;
    out_ready = rd;
    in_pc     = pc;
    in_instr  = $urandom();
    #1;
  endtask

  task automatic step();
    bit rst, fl, pu, po, by, rd;
    logic [63:0] d, junk;
    rst = rst_n;
    fl  = flush;
    rd  = out_ready;
    pu  = in_valid && e_ready();
    po  = e_valid() && out_ready;
    by  = e_byp();
    d   = {in_instr, in_pc};
    @(posedge clk);
    rdy_m = rst;
    if (!rst || fl) q.delete();
    else if (!(by && rd)) begin
      if (po) junk = q.pop_front();
      if (pu) q.push_back(d);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 32'h40);
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_hs got rdy=%b vld=%b want 0/0", in_ready, out_valid);
      end
      tests++;
      if (count !== 3'd0 || out_pc !== '0 || out_instr !== '0) begin
        fails++;
        $display("FAIL reset_out got cnt=%0d pc=%h ins=%h want 0", count, out_pc, out_instr);
      end
      step();
    end
    drive(1, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release in_ready got %b want 1", in_ready);
    end
    step();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 0, 32'h100 + 32'(4*i));
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL fill_ready[%0d] got %b want 1", i, in_ready);
      end
      step();
    end
    drive(1, 0, 0, 0, 0);
    tests++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_full got cnt=%0d rdy=%b want 4/0", count, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, 0);
      tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4*i)) begin
        fails++;
        $display("FAIL drain[%0d] got vld=%b pc=%h want 1/%h",
                 i, out_valid, out_pc, 32'h100 + 32'(4*i));
      end
      step();
    end
    drive(1, 0, 0, 1, 0);
    tests++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      fails++;
      $display("FAIL drain_end got vld=%b cnt=%0d want 0/0", out_valid, count);
    end
    step();
  endtask

  task automatic test_wrap();
    logic [31:0] got[$];
    int sent = 0;
    for (int cyc = 0; cyc < 200 && got.size() < 10; cyc++) begin
      drive(1, 0, sent < 10, cyc[0], 32'h200 + 32'(4*sent));
      tests++;
      if (in_ready !== e_ready() || out_valid !== e_valid() ||
          {out_instr, out_pc} !== e_data() || count !== 3'(q.size()) ||
          count > 3'd4) begin
        fails++;
        $display("FAIL wrap_cyc%0d got rdy=%b vld=%b pc=%h cnt=%0d want %b/%b/%h/%0d",
                 cyc, in_ready, out_valid, out_pc, count,
                 e_ready(), e_valid(), e_data()[31:0], q.size());
      end
      if (out_valid && out_ready) got.push_back(out_pc);
      if (in_valid && e_ready()) sent++;
      step();
    end
    tests++;
    if (got.size() != 10) begin
      fails++;
      $display("FAIL wrap_timeout got %0d outputs want 10", got.size());
    end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      tests++;
      if (got[i] !== 32'h200 + 32'(4*i)) begin
        fails++;
        $display("FAIL wrap_order[%0d] got %h want %h", i, got[i], 32'h200 + 32'(4*i));
      end
    end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 10 && q.size() < 4; i++) begin
      drive(1, 0, 1, 0, 32'h500 + 32'(4*i));
      step();
    end
    drive(1, 0, 1, 1, 32'h5F0);
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL full_simul got rdy=%b vld=%b want 0/1", in_ready, out_valid);
    end
    step();
    drive(1, 0, 1, 0, 32'h5F0);
    tests++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL full_after got cnt=%0d rdy=%b want 3/1", count, in_ready);
    end
    step();
    drive(1, 0, 0, 0, 0);
    tests++;
    if (count !== 3'd4) begin
      fails++;
      $display("FAIL full_refill count got %0d want 4", count);
    end
    step();
    drive(1, 1, 0, 0, 0);
    step();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 32'h380 + 32'(4*i));
      step();
    end
    drive(1, 1, 1, 1, 32'h300);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_cycle got vld=%b rdy=%b want 0/0", out_valid, in_ready);
    end
    step();
    drive(1, 0, 0, 1, 0);
    tests++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_after got cnt=%0d vld=%b rdy=%b want 0/0/1",
               count, out_valid, in_ready);
    end
    step();
    drive(1, 0, 1, 0, 32'h310);
    step();
    drive(1, 0, 0, 1, 0);
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h310) begin
      fails++;
      $display("FAIL flush_next got vld=%b pc=%h want 1/00000310", out_valid, out_pc);
    end
    step();
    drive(1, 0, 0, 1, 0);
    tests++;
    if (out_valid !== 1'b0 || out_pc === 32'h300) begin
      fails++;
      $display("FAIL flush_drop got vld=%b pc=%h want 0/0", out_valid, out_pc);
    end
    step();
  endtask

  task automatic test_bypass();
    drive(1, 0, 1, 1, 32'h400);
`ifdef FETCH_QUEUE_BYPASS_EN
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h400 || out_instr !== in_instr) begin
      fails++;
      $display("FAIL bypass_same got vld=%b pc=%h want 1/00000400", out_valid, out_pc);
    end
    step();
    drive(1, 0, 0, 1, 0);
    tests++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bypass_cnt got cnt=%0d vld=%b want 0/0", count, out_valid);
    end
    step();
`else
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL nobypass_same out_valid got %b want 0", out_valid);
    end
    step();
    drive(1, 0, 0, 1, 0);
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h400) begin
      fails++;
      $display("FAIL nobypass_next got vld=%b pc=%h want 1/00000400", out_valid, out_pc);
    end
    step();
    drive(1, 0, 0, 1, 0);
    tests++;
    if (count !== 3'd0) begin
      fails++;
      $display("FAIL nobypass_cnt count got %0d want 0", count);
    end
    step();
`endif
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive($urandom_range(49) != 0, $urandom_range(15) == 0,
            $urandom_range(2) != 0, $urandom_range(1) != 0, $urandom());
      tests++;
      if (in_ready !== e_ready() || out_valid !== e_valid() ||
          {out_instr, out_pc} !== e_data() || count !== 3'(q.size())) begin
        fails++;
        $display("FAIL rand_cyc%0d got rdy=%b vld=%b ins=%h pc=%h cnt=%0d want %b/%b/%h/%0d",
                 cyc, in_ready, out_valid, out_instr, out_pc, count,
                 e_ready(), e_valid(), e_data(), q.size());
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_simul();
    test_flush();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
